// File: rtl/csi_raw10_unpack_pkg.sv
// Shared CSI-2 unpacker definitions: data types, FSM encoding, RAW10 group packing.
// Intended for reuse by the RAW8/RAW12 unpackers.
package csi_raw10_unpack_pkg;

  localparam logic [5:0] DT_RAW10    = 6'h2B;
  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;
  localparam logic [5:0] DT_LONG_MIN = 6'h10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } unpack_state_e;

  // b[7:0] is B0 (first on the wire) and b[39:32] is B4, which holds the low 2 bits of each pixel.
  function automatic logic [39:0] raw10_pack(input logic [39:0] b);
    return {b[7:0],   b[33:32],
            b[15:8],  b[35:34],
            b[23:16], b[37:36],
            b[31:24], b[39:38]};
  endfunction

endpackage

// File: rtl/csi_raw10_unpack_if.sv
// Lane-merger side inputs and pixel-FIFO side outputs of the RAW10 unpacker.
interface csi_raw10_unpack_if #(
  parameter int LINE_W = 12
);
  logic              hdr_vld;
  logic [5:0]        hdr_dt;
  logic [15:0]       hdr_wc;
  logic [31:0]       pay_data;
  logic              pay_vld;
  logic [39:0]       pixel_data;
  logic              pixel_vld;
  logic              frame_start;
  logic              frame_end;
  logic [LINE_W-1:0] line_cnt;
  logic              err_len;

  modport master (
    output hdr_vld, hdr_dt, hdr_wc, pay_data, pay_vld,
    input  pixel_data, pixel_vld, frame_start, frame_end, line_cnt, err_len
  );

  modport slave (
    input  hdr_vld, hdr_dt, hdr_wc, pay_data, pay_vld,
    output pixel_data, pixel_vld, frame_start, frame_end, line_cnt, err_len
  );
endinterface

// File: rtl/csi_raw10_unpack_raw10_byte_acc.sv
// Byte accumulator: appends up to 4 bytes per beat and pulls out one 5-byte RAW10 group
// when enough bytes are buffered. The buffered count never exceeds 4 between beats.
module raw10_byte_acc
  import csi_raw10_unpack_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_bytes,
  input  logic [2:0]  in_n,
  input  logic        flush,
  output logic [2:0]  acc_cnt,
  output logic [39:0] grp,
  output logic        grp_vld
);

  logic [7:0]  buf_q [0:7];
  logic [7:0]  buf_d [0:7];
  logic [7:0]  tmp   [0:7];
  logic [7:0]  shifted [0:7];
  logic [2:0]  acc_q, acc_d;
  logic [3:0]  total;
  logic [3:0]  rem;
  logic        extract;
  logic [39:0] grp_q, grp_d;
  logic        grp_vld_q, grp_vld_d;

  for (genvar gi = 0; gi < 8; gi++) begin : g_shift
    if (gi < 3) begin : g_keep
      assign shifted[gi] = tmp[gi+5];
    end else begin : g_zero
      assign shifted[gi] = 8'h00;
    end
  end

  always_comb begin
    tmp = buf_q;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < in_n) tmp[acc_q + 3'(i)] = in_bytes[8*i +: 8];
    end
    total   = {1'b0, acc_q} + {1'b0, in_n};
    extract = (total >= 4'd5);
    rem     = extract ? (total - 4'd5) : total;
    for (int i = 0; i < 8; i++) begin
      buf_d[i] = extract ? shifted[i] : tmp[i];
    end
    // A flush still lets this beat's group out; only the residue is dropped.
    acc_d     = flush ? 3'd0 : rem[2:0];
    grp_vld_d = extract;
    grp_d     = extract ? raw10_pack({tmp[4], tmp[3], tmp[2], tmp[1], tmp[0]}) : grp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) buf_q[i] <= 8'h00;
      acc_q     <= 3'd0;
      grp_q     <= 40'd0;
      grp_vld_q <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      acc_q     <= acc_d;
      grp_q     <= grp_d;
      grp_vld_q <= grp_vld_d;
    end
  end

  assign acc_cnt = acc_q;
  assign grp     = grp_q;
  assign grp_vld = grp_vld_q;

endmodule

// File: rtl/csi_raw10_unpack.sv
// RAW10 long-packet unpacker: header FSM, line counting, frame markers and length errors.
// Payload bytes go through raw10_byte_acc, which emits the registered pixel groups.
module csi_raw10_unpack
  import csi_raw10_unpack_pkg::*;
#(
  parameter int LINE_W = 12
) (
  input  logic              wfifo_wr_clk,
  input  logic              s_rst_n,
  csi_raw10_unpack_if.slave bus
);

  unpack_state_e     state_q, state_d;
  logic [15:0]       left_q, left_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              fs_q, fs_d;
  logic              fe_q, fe_d;
  logic              err_q, err_d;
  logic [2:0]        beat_n;
  logic [2:0]        acc_n_in;
  logic              acc_flush;
  logic [2:0]        acc_cnt;
  logic [3:0]        total;

  raw10_byte_acc u_acc (
    .clk      (wfifo_wr_clk),
    .rst_n    (s_rst_n),
    .in_bytes (bus.pay_data),
    .in_n     (acc_n_in),
    .flush    (acc_flush),
    .acc_cnt  (acc_cnt),
    .grp      (bus.pixel_data),
    .grp_vld  (bus.pixel_vld)
  );

  always_comb begin
    state_d   = state_q;
    left_d    = left_q;
    line_d    = line_q;
    fs_d      = 1'b0;
    fe_d      = 1'b0;
    err_d     = 1'b0;
    acc_n_in  = 3'd0;
    acc_flush = 1'b0;
    beat_n    = (left_q >= 16'd4) ? 3'd4 : left_q[2:0];
    total     = {1'b0, acc_cnt} + {1'b0, beat_n};

    if (bus.hdr_vld) begin
      // A header mid-packet aborts it, then is handled exactly as from IDLE.
      if (state_q != ST_IDLE) begin
        acc_flush = 1'b1;
        err_d     = (state_q == ST_PAYLOAD);
      end
      state_d = ST_IDLE;
      left_d  = 16'd0;
      if (bus.hdr_dt == DT_FS) begin
        fs_d   = 1'b1;
        line_d = '0;
      end else if (bus.hdr_dt == DT_FE) begin
        fe_d = 1'b1;
      end else if (bus.hdr_wc != 16'd0) begin
        if (bus.hdr_dt == DT_RAW10) begin
          left_d  = bus.hdr_wc;
          state_d = ST_PAYLOAD;
        end else if (bus.hdr_dt >= DT_LONG_MIN) begin
          left_d  = bus.hdr_wc;
          state_d = ST_DROP;
        end
      end
    end else if (bus.pay_vld && state_q != ST_IDLE) begin
      left_d = left_q - 16'(beat_n);
      if (state_q == ST_PAYLOAD) acc_n_in = beat_n;
      if (left_d == 16'd0) begin
        state_d = ST_IDLE;
        if (state_q == ST_PAYLOAD) begin
          line_d    = line_q + 1'b1;
          acc_flush = 1'b1;
          // Exactly five bytes on the last beat means nothing is left over.
          err_d     = (total != 4'd5);
        end
      end
    end
  end

  always_ff @(posedge wfifo_wr_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= ST_IDLE;
      left_q  <= 16'd0;
      line_q  <= '0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      line_q  <= line_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      err_q   <= err_d;
    end
  end

  assign bus.frame_start = fs_q;
  assign bus.frame_end   = fe_q;
  assign bus.line_cnt    = line_q;
  assign bus.err_len     = err_q;

endmodule

// File: tb/tb_csi_raw10_unpack.sv
// Randomised bench for csi_raw10_unpack: a byte-queue model predicts every output event
// (pixel group, err_len, frame_start, frame_end) with the cycle it must appear in.
module tb_csi_raw10_unpack;

  typedef logic [79:0] ev_t; // {kind, cycle, data}
  localparam int EV_PIX = 1, EV_ERR = 2, EV_FS = 3, EV_FE = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   last_beat_cyc = 0;

  ev_t        got_q[$];
  ev_t        exp_q[$];
  logic [7:0] byte_q[$];
  int         m_state = 0; // 0 idle, 1 raw10 payload, 2 dropped payload
  int         m_left  = 0;
  int         line_m  = 0;

  csi_raw10_unpack_if #(.LINE_W(12)) bus ();

  csi_raw10_unpack #(.LINE_W(12)) dut (
    .wfifo_wr_clk (clk),
    .s_rst_n      (rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pixel_vld) begin
        got_q.push_back(mk(EV_PIX, cyc, bus.pixel_data));
        $display("pix   cyc=%0d data=%010h", cyc, bus.pixel_data);
      end
      if (bus.err_len)     got_q.push_back(mk(EV_ERR, cyc, 40'd0));
      if (bus.frame_start) got_q.push_back(mk(EV_FS, cyc, 40'd0));
      if (bus.frame_end)   got_q.push_back(mk(EV_FE, cyc, 40'd0));
    end
  end

  function automatic ev_t mk(int k, int c, logic [39:0] d);
    return {8'(k), 32'(c), d};
  endfunction

  // Pixel k = 8 MSBs from byte k, 2 LSBs from bits [2k+1:2k] of the fifth byte.
  function automatic logic [39:0] model_pack(logic [7:0] b [0:4]);
    logic [39:0] r = 40'd0;
    for (int k = 0; k < 4; k++) begin
      int p = int'(b[k]) * 4 + ((int'(b[4]) >> (2 * k)) & 3);
      r = r | (40'(p) << (30 - 10 * k));
    end
    return r;
  endfunction

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_hdr(logic [5:0] dt, logic [15:0] wc);
    @(negedge clk);
    bus.hdr_vld = 1'b1;
    bus.hdr_dt  = dt;
    bus.hdr_wc  = wc;
    if (m_state == 1) exp_q.push_back(mk(EV_ERR, cyc + 1, 40'd0));
    byte_q.delete();
    m_state = 0;
    if (dt == 6'h00) begin
      line_m = 0;
      exp_q.push_back(mk(EV_FS, cyc + 1, 40'd0));
    end else if (dt == 6'h01) begin
      exp_q.push_back(mk(EV_FE, cyc + 1, 40'd0));
    end else if (wc != 0 && dt == 6'h2B) begin
      m_state = 1;
      m_left  = int'(wc);
    end else if (wc != 0 && dt >= 6'h10) begin
      m_state = 2;
      m_left  = int'(wc);
    end
    $display("hdr   cyc=%0d dt=%02h wc=%0d", cyc, dt, wc);
    @(posedge clk);
    #1;
    bus.hdr_vld = 1'b0;
  endtask

  task automatic send_beat(logic [31:0] w);
    int n;
    logic [7:0] b [0:4];
    @(negedge clk);
    bus.pay_vld  = 1'b1;
    bus.pay_data = w;
    last_beat_cyc = cyc;
    if (m_state != 0) begin
      n = (m_left < 4) ? m_left : 4;
      if (m_state == 1) for (int i = 0; i < n; i++) byte_q.push_back(w[8*i +: 8]);
      m_left -= n;
      if (byte_q.size() >= 5) begin
        for (int i = 0; i < 5; i++) b[i] = byte_q.pop_front();
        exp_q.push_back(mk(EV_PIX, cyc + 1, model_pack(b)));
      end
      if (m_left == 0) begin
        if (m_state == 1) begin
          line_m++;
          if (byte_q.size() != 0) exp_q.push_back(mk(EV_ERR, cyc + 1, 40'd0));
        end
        byte_q.delete();
        m_state = 0;
      end
    end
    @(posedge clk);
    #1;
    bus.pay_vld = 1'b0;
  endtask

  task automatic send_line(logic [15:0] wc, int max_gap);
    send_hdr(6'h2B, wc);
    for (int i = 0; i < (int'(wc) + 3) / 4; i++) begin
      if (max_gap > 0) idle($urandom_range(max_gap));
      send_beat($urandom);
    end
  endtask

  task automatic test_reset();
    bus.hdr_vld = 1'b0; bus.hdr_dt = 6'd0; bus.hdr_wc = 16'd0;
    bus.pay_vld = 1'b0; bus.pay_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.pixel_data, bus.pixel_vld, bus.frame_start, bus.frame_end, bus.line_cnt, bus.err_len} !== 56'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {bus.pixel_data, bus.pixel_vld, bus.frame_start,
               bus.frame_end, bus.line_cnt, bus.err_len});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_line();
    int w2;
    send_hdr(6'h00, 16'd0);
    send_hdr(6'h2B, 16'd10);
    send_beat(32'h04030201);
    send_beat(32'h08070605);
    w2 = last_beat_cyc;
    send_beat(32'h0C0B0A09);
    idle(2);
    total++;
    if (got_q.size() < 2 || got_q[1] !== mk(EV_PIX, w2 + 1, 40'h0140903010)) begin
      bad++;
      $display("FAIL first_group got=%h want=%h", (got_q.size() > 1) ? got_q[1] : '0,
               mk(EV_PIX, w2 + 1, 40'h0140903010));
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL first_line_events got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL first_line_ev%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    total++;
    if (bus.line_cnt !== 12'd1) begin bad++; $display("FAIL first_line_cnt got=%0d want=1", bus.line_cnt); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int npix = 0;
    send_hdr(6'h00, 16'd0);
    repeat (4) send_line(16'd20, 0);
    send_hdr(6'h01, 16'd0);
    idle(2);
    foreach (got_q[i]) if (got_q[i][79:72] == 8'(EV_PIX)) npix++;
    total++;
    if (npix != 16) begin bad++; $display("FAIL b2b_pixel_count got=%0d want=16", npix); end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL b2b_events got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_ev%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    total++;
    if (bus.line_cnt !== 12'd4) begin bad++; $display("FAIL b2b_line_cnt got=%0d want=4", bus.line_cnt); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_short_wc_and_drop();
    send_line(16'd7, 0);
    send_line(16'd10, 1);
    send_hdr(6'h2A, 16'd8);
    send_beat($urandom);
    send_beat($urandom);
    send_beat($urandom);
    idle(2);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL wc7_drop_events got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL wc7_drop_ev%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    total++;
    if (bus.line_cnt !== 12'(line_m)) begin bad++; $display("FAIL wc7_drop_line_cnt got=%0d want=%0d", bus.line_cnt, line_m); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_abort();
    send_hdr(6'h2B, 16'd20);
    send_beat($urandom);
    send_beat($urandom);
    send_line(16'd10, 0);
    idle(2);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL abort_events got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL abort_ev%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    total++;
    if (bus.line_cnt !== 12'(line_m)) begin bad++; $display("FAIL abort_line_cnt got=%0d want=%0d", bus.line_cnt, line_m); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_line();
    send_hdr(6'h2B, 16'd20);
    repeat (3) send_beat($urandom);
    idle(1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.pixel_data, bus.pixel_vld, bus.frame_start, bus.frame_end, bus.line_cnt, bus.err_len} !== 56'd0) begin
      bad++;
      $display("FAIL midreset_outputs got=%h want=0", {bus.pixel_data, bus.pixel_vld, bus.frame_start,
               bus.frame_end, bus.line_cnt, bus.err_len});
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL midreset_pre_events got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    got_q.delete(); exp_q.delete(); byte_q.delete();
    m_state = 0; line_m = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_line(16'd10, 0);
    idle(2);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL midreset_events got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL midreset_ev%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    total++;
    if (bus.line_cnt !== 12'd1) begin bad++; $display("FAIL midreset_line_cnt got=%0d want=1", bus.line_cnt); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random_lines();
    int wc, nb;
    send_hdr(6'h00, 16'd0);
    for (int l = 0; l < 12; l++) begin
      wc = $urandom_range(40, 1);
      nb = (wc + 3) / 4;
      // Roughly one line in four is cut short by the next header.
      if ($urandom_range(3) == 0) nb = $urandom_range(nb - 1, 0);
      send_hdr(($urandom_range(4) == 0) ? 6'h12 : 6'h2B, 16'(wc));
      for (int i = 0; i < nb; i++) begin
        idle($urandom_range(2));
        send_beat($urandom);
      end
    end
    send_hdr(6'h01, 16'd0);
    idle(2);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL random_events got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL random_ev%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    total++;
    if (bus.line_cnt !== 12'(line_m)) begin bad++; $display("FAIL random_line_cnt got=%0d want=%0d", bus.line_cnt, line_m); end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_back_to_back();
    test_short_wc_and_drop();
    test_abort();
    test_reset_mid_line();
    test_random_lines();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
